debounce_toggle_gen: RTL and testbench

DEBOUNCE_TOGGLE_GEN -- requirements
Module: debounce_toggle_gen

---
 rtl/debounce_toggle_gen.sv | 123 ++++++++++++
 tb/tb_debounce_toggle_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/debounce_toggle_gen.sv
// Debounced toggle-request generator.
// Synchronizes a raw bouncy level, qualifies each level change with
// DEBOUNCE_CYCLES consecutive equal samples, and emits one registered
// single-cycle pulse per accepted press to drive a downstream T flip-flop.
//
// Ports
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   i_btn    raw asynchronous toggle-request level
//   o_t      one-cycle toggle pulse per accepted press
//   o_level  debounced level
//   o_busy   high while a level change is being qualified
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | debounced level low, waiting for a high sample
// CHK_HI  | counting consecutive high samples toward a press
// PRESSED | debounced level high, waiting for a low sample
// CHK_LO  | counting consecutive low samples toward a release
module debounce_toggle_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_t,
   output logic o_level,
   output logic o_busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHK_HI  = 2'd1,
      PRESSED = 2'd2,
      CHK_LO  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s2;
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             fire;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (s2) begin
               state_d = CHK_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         CHK_HI: begin
            if (!s2) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!s2) begin
               state_d = CHK_LO;
               cnt_d   = CNT_ONE;
            end
         end
         CHK_LO: begin
            // A high sample here is a release glitch: fall back to PRESSED
            // without raising another pulse.
            if (s2) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The pulse is tied to the press-acceptance transition itself, so it can
   // only ever appear once per pass through CHK_HI.
   assign fire = (state_q == CHK_HI) && (state_d == PRESSED);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         o_t     <= 1'b0;
         o_level <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         s1      <= i_btn;
         s2      <= s1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         o_t     <= fire;
         o_level <= (state_d == PRESSED) || (state_d == CHK_LO);
         o_busy  <= (state_d == CHK_HI)  || (state_d == CHK_LO);
      end
   end

endmodule

// File: tb/tb_debounce_toggle_gen.sv
module tb_debounce_toggle_gen;

   logic clk;
   logic reset;
   logic i_btn;
   logic o_t;
   logic o_level;
   logic o_busy;

   int   total;
   int   bad;
   logic tff;
   int   toggles;

   debounce_toggle_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (i_btn),
      .o_t     (o_t),
      .o_level (o_level),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream T flip-flop driven by o_t, plus a toggle counter.
   always @(posedge clk) begin
      if (reset) begin
         tff     <= 1'b0;
         toggles <= 0;
      end else if (o_t) begin
         tff     <= ~tff;
         toggles <= toggles + 1;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int t, input int lvl, input int busy);
      chk({tag, ".o_t"},     int'(o_t),     t);
      chk({tag, ".o_level"}, int'(o_level), lvl);
      chk({tag, ".o_busy"},  int'(o_busy),  busy);
   endtask

   // Hold i_btn at 'lvl' for n edges with no checking.
   task automatic hold(input logic lvl, input int n);
      i_btn = lvl;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Clean press: pulse after edge 6, busy after edges 3..5, level from edge 6.
   task automatic press_check(input string tag);
      i_btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_out(tag, (i == 6) ? 1 : 0, (i >= 6) ? 1 : 0, (i >= 3 && i <= 5) ? 1 : 0);
      end
   endtask

   // Clean release: level falls after edge 6, busy after edges 3..5, no pulse.
   task automatic release_check(input string tag);
      i_btn = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk_out(tag, 0, (i < 6) ? 1 : 0, (i >= 3 && i <= 5) ? 1 : 0);
      end
   endtask

   initial begin
      logic [5:0] bounce;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      i_btn = 1'b0;

      // Reset state.
      tick();
      tick();
      chk_out("reset", 0, 0, 0);
      reset = 1'b0;
      hold(1'b0, 3);
      chk_out("idle", 0, 0, 0);

      press_check("press");
      release_check("release");

      // Bounce: sample pattern 1,1,0,1,1,0 then low.
      bounce = 6'b011011;
      for (int i = 0; i < 12; i++) begin
         i_btn = (i < 6) ? bounce[i] : 1'b0;
         tick();
         chk("bounce.o_t", int'(o_t), 0);
         chk("bounce.o_level", int'(o_level), 0);
      end

      // Release glitch: two low samples while pressed.
      press_check("press2");
      i_btn = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 3) i_btn = 1'b1;
         tick();
         chk("glitch.o_t", int'(o_t), 0);
         chk("glitch.o_level", int'(o_level), 1);
      end
      release_check("release2");

      // Reset while in CHK_HI with cnt=2 (after edge 4 of a press).
      i_btn = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("midrst.busy_before", int'(o_busy), 1);
      reset = 1'b1;
      tick();
      chk_out("midrst", 0, 0, 0);
      reset = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk_out("postrst", (i == 6) ? 1 : 0, (i >= 6) ? 1 : 0, (i >= 3 && i <= 5) ? 1 : 0);
      end
      release_check("release3");

      // Reset on the very edge the pulse is due: pulse suppressed.
      i_btn = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      chk_out("rstprio", 0, 0, 0);
      i_btn = 1'b0;
      tick();
      reset = 1'b0;
      hold(1'b0, 4);
      chk_out("rstprio.after", 0, 0, 0);

      // Chain: three clean presses through the T flip-flop (reset above cleared it).
      chk("chain.tff0", int'(tff), 0);
      for (int p = 1; p <= 3; p++) begin
         hold(1'b1, 8);
         chk("chain.tff", int'(tff), p % 2);
         hold(1'b0, 8);
      end
      chk("chain.toggles", toggles, 3);
      chk("chain.tff_final", int'(tff), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
